otter_branch_predictor: RTL and testbench

- Parametrised branch target buffer with a saturating-counter direction predictor for the pipelined OTTER.
- Lets fetch follow predicted-taken branches and JALs instead of always taking PC+4, so only mispredicted control transfers cost a flush.
- Lookup is served to the fetch stage and training comes from the execute stage.
- Also produces the execute-stage mispredict/redirect signals and keeps performance counters.

---
 rtl/otter_pkg.sv | 34 +++
 rtl/otter_sat_counter.sv | 37 +++
 rtl/otter_branch_predictor.sv | 156 +++++++++++++++
 tb/tb_otter_branch_predictor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode encodings, default BTB geometry and the
// BTB entry layout, plus small PC helpers used by the predictor.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = 30 - BTB_IDX_W;
    localparam int BTB_CNT_W   = 2;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [29:0]          target;
        logic [BTB_CNT_W-1:0] cnt;
    } btb_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up/down counter with parallel load; never wraps at 0 or all-ones.
module otter_sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && !dec && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: zero-cycle
// fetch lookup, execute-stage training, mispredict/redirect and perf counters.
module otter_branch_predictor
    import otter_pkg::*;
#(
    parameter int ENTRIES     = 16,
    parameter int CNT_W       = 2,
    parameter int PREDICT_JAL = 1,
    parameter int STAT_W      = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       FE_PC,
    input  logic              FE_VALID,
    output logic              PRED_TAKEN,
    output logic [31:0]       PRED_TARGET,
    input  logic              EX_VALID,
    input  logic [31:0]       EX_PC,
    input  logic              EX_IS_BRANCH,
    input  logic              EX_IS_JAL,
    input  logic              EX_TAKEN,
    input  logic [31:0]       EX_TARGET,
    input  logic              EX_PRED_TAKEN,
    input  logic [31:0]       EX_PRED_TARGET,
    input  logic              FLUSH_ALL,
    output logic              MISPREDICT,
    output logic [31:0]       REDIRECT_PC,
    output logic [STAT_W-1:0] STAT_LOOKUPS,
    output logic [STAT_W-1:0] STAT_MISPRED
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [29:0]        tgt_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];

    logic [IDX_W-1:0]   fe_idx, ex_idx;
    logic [TAG_W-1:0]   fe_tag, ex_tag;
    logic               fe_hit, ex_hit, ex_ctrl, ex_wrong;
    logic               train, upd_en, alias_clr;
    logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;

    // Fetch-side lookup reads only registered state, so a same-cycle update
    // to the same index is never visible here.
    assign fe_idx      = FE_PC[IDX_W+1:2];
    assign fe_tag      = FE_PC[31:IDX_W+2];
    assign fe_hit      = FE_VALID & valid_q[fe_idx] & (tag_q[fe_idx] == fe_tag);
    assign PRED_TAKEN  = fe_hit & cnt_q[fe_idx][CNT_W-1];
    assign PRED_TARGET = PRED_TAKEN ? {tgt_q[fe_idx], 2'b00} : pc_plus4(FE_PC);

    assign ex_idx   = EX_PC[IDX_W+1:2];
    assign ex_tag   = EX_PC[31:IDX_W+2];
    assign ex_hit   = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    assign ex_ctrl  = EX_IS_BRANCH | EX_IS_JAL;
    assign ex_wrong = (EX_PRED_TAKEN != EX_TAKEN) |
                      (EX_TAKEN & (EX_PRED_TARGET != EX_TARGET));

    // A non-control instruction that was predicted taken is a stale alias.
    assign MISPREDICT  = EX_VALID & (ex_ctrl ? ex_wrong : EX_PRED_TAKEN);
    assign REDIRECT_PC = EX_TAKEN ? EX_TARGET : pc_plus4(EX_PC);

    assign train     = EX_VALID & (EX_IS_BRANCH | (EX_IS_JAL & (PREDICT_JAL != 0)));
    assign upd_en    = train & ~FLUSH_ALL;
    assign alias_clr = EX_VALID & ~ex_ctrl & EX_PRED_TAKEN & ex_hit & ~FLUSH_ALL;

    always_comb begin
        valid_d = valid_q;
        if (FLUSH_ALL) begin
            valid_d = '0;
        end else if (upd_en && EX_TAKEN && !ex_hit) begin
            valid_d[ex_idx] = 1'b1;
        end else if (alias_clr) begin
            valid_d[ex_idx] = 1'b0;
        end
    end

    // Taken resolutions rewrite tag and target; on a hit the tag is unchanged.
    always_comb begin
        tag_d = tag_q;
        tgt_d = tgt_q;
        if (upd_en && EX_TAKEN) begin
            tag_d[ex_idx] = ex_tag;
            tgt_d[ex_idx] = EX_TARGET[31:2];
        end
    end

    always_comb begin
        cnt_inc  = '0;
        cnt_dec  = '0;
        cnt_load = '0;
        if (upd_en) begin
            if (ex_hit) begin
                if (EX_TAKEN) cnt_inc[ex_idx] = 1'b1;
                else          cnt_dec[ex_idx] = 1'b1;
            end else if (EX_TAKEN) begin
                cnt_load[ex_idx] = 1'b1;
            end
        end
    end

    assign cnt_load_val = EX_IS_BRANCH ? CNT_WEAK : CNT_MAX;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        otter_sat_counter #(.W(CNT_W)) u_cnt (
            .clk      (CLK),
            .rst_n    (RESET_N),
            .inc      (cnt_inc[i]),
            .dec      (cnt_dec[i]),
            .load     (cnt_load[i]),
            .load_val (cnt_load_val),
            .q        (cnt_q[i])
        );
    end

    otter_sat_counter #(.W(STAT_W)) u_stat_lookups (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .inc      (FE_VALID),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .q        (STAT_LOOKUPS)
    );

    otter_sat_counter #(.W(STAT_W)) u_stat_mispred (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .inc      (MISPREDICT),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .q        (STAT_MISPRED)
    );

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed plus randomized bench for otter_branch_predictor; two instances
// (PREDICT_JAL=1 and 0) share stimulus and are checked against an array model.
module tb_otter_branch_predictor;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] FE_PC;
    logic        FE_VALID;
    logic        EX_VALID, EX_IS_BRANCH, EX_IS_JAL, EX_TAKEN, EX_PRED_TAKEN, FLUSH_ALL;
    logic [31:0] EX_PC, EX_TARGET, EX_PRED_TARGET;

    logic        pred_taken  [2];
    logic [31:0] pred_target [2];
    logic        mispredict  [2];
    logic [31:0] redirect_pc [2];
    logic [31:0] stat_look   [2];
    logic [31:0] stat_mis    [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: index 0 models PREDICT_JAL=1, index 1 PREDICT_JAL=0.
    bit          mv   [2][16];
    int unsigned mtag [2][16];
    int unsigned mtgt [2][16];
    int          mcnt [2][16];
    longint      mlook, mmis;

    always #5 CLK = ~CLK;

    otter_branch_predictor #(.ENTRIES(16), .CNT_W(2), .PREDICT_JAL(1), .STAT_W(32)) dut_j (
        .CLK(CLK), .RESET_N(RESET_N), .FE_PC(FE_PC), .FE_VALID(FE_VALID),
        .PRED_TAKEN(pred_taken[0]), .PRED_TARGET(pred_target[0]),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IS_BRANCH(EX_IS_BRANCH), .EX_IS_JAL(EX_IS_JAL),
        .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET), .EX_PRED_TAKEN(EX_PRED_TAKEN),
        .EX_PRED_TARGET(EX_PRED_TARGET), .FLUSH_ALL(FLUSH_ALL),
        .MISPREDICT(mispredict[0]), .REDIRECT_PC(redirect_pc[0]),
        .STAT_LOOKUPS(stat_look[0]), .STAT_MISPRED(stat_mis[0])
    );

    otter_branch_predictor #(.ENTRIES(16), .CNT_W(2), .PREDICT_JAL(0), .STAT_W(32)) dut_n (
        .CLK(CLK), .RESET_N(RESET_N), .FE_PC(FE_PC), .FE_VALID(FE_VALID),
        .PRED_TAKEN(pred_taken[1]), .PRED_TARGET(pred_target[1]),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IS_BRANCH(EX_IS_BRANCH), .EX_IS_JAL(EX_IS_JAL),
        .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET), .EX_PRED_TAKEN(EX_PRED_TAKEN),
        .EX_PRED_TARGET(EX_PRED_TARGET), .FLUSH_ALL(FLUSH_ALL),
        .MISPREDICT(mispredict[1]), .REDIRECT_PC(redirect_pc[1]),
        .STAT_LOOKUPS(stat_look[1]), .STAT_MISPRED(stat_mis[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                mv[k][i]   = 1'b0;
                mcnt[k][i] = 0;
            end
        mlook = 0;
        mmis  = 0;
    endfunction

    function automatic void m_lookup(input int k, input bit v, input int unsigned pc,
                                     output bit tk, output int unsigned tg);
        int idx;
        bit hit;
        idx = (pc >> 2) % 16;
        hit = v && mv[k][idx] && (mtag[k][idx] == (pc >> 6));
        tk  = hit && (mcnt[k][idx] >= 2);
        tg  = tk ? mtgt[k][idx] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        bit ctrl;
        ctrl = EX_IS_BRANCH || EX_IS_JAL;
        if (!EX_VALID) return 1'b0;
        if (!ctrl) return EX_PRED_TAKEN;
        return (EX_PRED_TAKEN != EX_TAKEN) || (EX_TAKEN && (EX_PRED_TARGET != EX_TARGET));
    endfunction

    function automatic void m_update(input int k, input bit pj);
        int idx;
        bit hit;
        idx = (EX_PC >> 2) % 16;
        hit = mv[k][idx] && (mtag[k][idx] == (EX_PC >> 6));
        if (FLUSH_ALL) begin
            for (int i = 0; i < 16; i++) mv[k][i] = 1'b0;
        end else if (EX_VALID && (EX_IS_BRANCH || (EX_IS_JAL && pj))) begin
            if (hit && EX_TAKEN) begin
                mcnt[k][idx] = (mcnt[k][idx] < 3) ? mcnt[k][idx] + 1 : 3;
                mtgt[k][idx] = EX_TARGET & ~32'h3;
            end else if (hit) begin
                mcnt[k][idx] = (mcnt[k][idx] > 0) ? mcnt[k][idx] - 1 : 0;
            end else if (EX_TAKEN) begin
                mv[k][idx]   = 1'b1;
                mtag[k][idx] = EX_PC >> 6;
                mtgt[k][idx] = EX_TARGET & ~32'h3;
                mcnt[k][idx] = EX_IS_BRANCH ? 2 : 3;
            end
        end else if (EX_VALID && !EX_IS_BRANCH && !EX_IS_JAL && EX_PRED_TAKEN && hit) begin
            mv[k][idx] = 1'b0;
        end
    endfunction

    task automatic fe_set(input bit v, input logic [31:0] pc);
        FE_VALID = v;
        FE_PC    = pc;
    endtask

    task automatic ex_set(input bit v, input logic [31:0] pc, input bit br, input bit jal,
                          input bit tk, input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
        EX_VALID       = v;
        EX_PC          = pc;
        EX_IS_BRANCH   = br;
        EX_IS_JAL      = jal;
        EX_TAKEN       = tk;
        EX_TARGET      = tg;
        EX_PRED_TAKEN  = ptk;
        EX_PRED_TARGET = ptg;
    endtask

    // Check every output against the model, then clock once and advance the model.
    task automatic cycle();
        bit          etk, emis;
        int unsigned etg;
        logic [31:0] eredir;
        #1;
        emis   = m_mispredict();
        eredir = EX_TAKEN ? EX_TARGET : EX_PC + 32'd4;
        for (int k = 0; k < 2; k++) begin
            m_lookup(k, FE_VALID, FE_PC, etk, etg);
            chk($sformatf("pred_taken[%0d]", k), 64'(pred_taken[k]), 64'(etk));
            chk($sformatf("pred_target[%0d]", k), 64'(pred_target[k]), 64'(etg));
            chk($sformatf("mispredict[%0d]", k), 64'(mispredict[k]), 64'(emis));
            chk($sformatf("redirect[%0d]", k), 64'(redirect_pc[k]), 64'(eredir));
            chk($sformatf("stat_look[%0d]", k), 64'(stat_look[k]), 64'(mlook));
            chk($sformatf("stat_mis[%0d]", k), 64'(stat_mis[k]), 64'(mmis));
        end
        @(posedge CLK);
        m_update(0, 1'b1);
        m_update(1, 1'b0);
        if (FE_VALID) mlook = mlook + 1;
        if (emis) mmis = mmis + 1;
        @(negedge CLK);
    endtask

    task automatic idle();
        fe_set(1'b0, 32'h0);
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        FLUSH_ALL = 1'b0;
    endtask

    int unsigned pool [6] = '{32'h40, 32'h440, 32'h80, 32'h14, 32'h10, 32'h1000_0040};

    initial begin
        bit          rtk;
        int unsigned rtg;
        int          kind;
        logic [31:0] epc;

        // Reset state
        RESET_N = 1'b0;
        idle();
        m_reset();
        fe_set(1'b1, 32'h100);
        #2;
        chk("rst_pred_taken", 64'(pred_taken[0]), 64'd0);
        chk("rst_pred_target", 64'(pred_target[0]), 64'h104);
        chk("rst_stat_look", 64'(stat_look[0]), 64'd0);
        chk("rst_stat_mis", 64'(stat_mis[1]), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        cycle();
        chk("t1_stat_look", 64'(stat_look[0]), 64'd1);

        // First taken branch allocates weakly taken
        idle();
        ex_set(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk("t2_mispredict", 64'(mispredict[0]), 64'd1);
        chk("t2_redirect", 64'(redirect_pc[0]), 64'h80);
        cycle();
        idle();
        fe_set(1'b1, 32'h40);
        #1;
        chk("t2_pred_taken", 64'(pred_taken[0]), 64'd1);
        chk("t2_pred_target", 64'(pred_target[0]), 64'h80);
        cycle();

        // Counter saturation and decay
        idle();
        for (int i = 0; i < 3; i++) begin
            ex_set(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
            cycle();
        end
        ex_set(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk("t3_nt_mispredict", 64'(mispredict[0]), 64'd1);
        chk("t3_nt_redirect", 64'(redirect_pc[0]), 64'h44);
        cycle();
        idle();
        fe_set(1'b1, 32'h40);
        #1;
        chk("t3_still_taken", 64'(pred_taken[0]), 64'd1);
        cycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
            cycle();
        end
        idle();
        fe_set(1'b1, 32'h40);
        #1;
        chk("t3_now_not_taken", 64'(pred_taken[0]), 64'd0);
        chk("t3_fallthrough", 64'(pred_target[0]), 64'h44);
        cycle();

        // Aliasing index with different tag
        idle();
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
            cycle();
        end
        idle();
        fe_set(1'b1, 32'h440);
        #1;
        chk("t4_alias_miss", 64'(pred_taken[0]), 64'd0);
        cycle();
        idle();
        ex_set(1'b1, 32'h440, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0);
        cycle();
        idle();
        fe_set(1'b1, 32'h40);
        #1;
        chk("t4_evicted", 64'(pred_taken[0]), 64'd0);
        cycle();
        fe_set(1'b1, 32'h440);
        #1;
        chk("t4_new_target", 64'(pred_target[0]), 64'h900);
        cycle();

        // JAL allocation depends on PREDICT_JAL
        idle();
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
            #1;
            chk("t5_jal_mis_n", 64'(mispredict[1]), 64'd1);
            cycle();
        end
        idle();
        fe_set(1'b1, 32'h10);
        #1;
        chk("t5_jal_pred_j", 64'(pred_target[0]), 64'h200);
        chk("t5_jal_pred_n", 64'(pred_taken[1]), 64'd0);
        cycle();

        // Flush with a same-cycle update to idx 5
        idle();
        FLUSH_ALL = 1'b1;
        ex_set(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        fe_set(1'b1, 32'h10);
        #1;
        chk("t6_flush_cycle_old", 64'(pred_taken[0]), 64'd1);
        cycle();
        idle();
        foreach (pool[i]) begin
            fe_set(1'b1, pool[i]);
            #1;
            chk("t6_flushed", 64'(pred_taken[0]), 64'd0);
            cycle();
        end

        // Asynchronous reset mid-cycle
        idle();
        ex_set(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
        cycle();
        idle();
        fe_set(1'b1, 32'h10);
        #2;
        RESET_N = 1'b0;
        #1;
        m_reset();
        chk("t6_rst_pred", 64'(pred_taken[0]), 64'd0);
        chk("t6_rst_target", 64'(pred_target[0]), 64'h14);
        chk("t6_rst_look", 64'(stat_look[0]), 64'd0);
        chk("t6_rst_mis", 64'(stat_mis[0]), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            FLUSH_ALL = ($urandom_range(0, 39) == 0);
            fe_set($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 4) != 0) ? pool[$urandom_range(0, 5)] : ($urandom & ~32'h3));
            kind = $urandom_range(0, 3);
            epc  = pool[$urandom_range(0, 5)];
            if (kind != 0) begin
                EX_VALID     = 1'b1;
                EX_PC        = epc;
                EX_IS_BRANCH = (kind == 1);
                EX_IS_JAL    = (kind == 2);
                EX_TAKEN     = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                EX_TARGET    = pool[$urandom_range(0, 5)] + 32'h100;
                if ($urandom_range(0, 1) != 0) begin
                    m_lookup(0, 1'b1, epc, rtk, rtg);
                    EX_PRED_TAKEN  = rtk;
                    EX_PRED_TARGET = rtg;
                end else begin
                    EX_PRED_TAKEN  = 1'($urandom_range(0, 1));
                    EX_PRED_TARGET = EX_TARGET;
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
